// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Optional feature macro: UART_PARITY_EN (adds the PARITY state and even-parity helper).
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 638;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_sched_if.sv
// Two-requester valid/ready byte interface into the UART transmit scheduler.
// Requesters drive valid/data through master; the scheduler answers ready through slave.
interface uart_tx_sched_if;
  import uart_pkg::*;

  logic                      req0_valid;
  logic [UART_DATA_BITS-1:0] req0_data;
  logic                      req0_ready;
  logic                      req1_valid;
  logic [UART_DATA_BITS-1:0] req1_data;
  logic                      req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled, restarts on clear,
// and pulses tc_o on the last count of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding two byte requesters into one 8N1 UART transmitter.
// Define UART_PARITY_EN to insert an even-parity bit between DATA and STOP (8E1).
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_sched_if.slave  req_if,
  output logic            txd,
  output logic            busy,
  output logic            grant_id
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_e                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      grant_q, grant_d;
  logic                      rr_last_q, rr_last_d;
  logic                      txd_q, txd_d;
  logic                      busy_q, busy_d;
  logic                      tc;
  logic                      sel;
  logic                      accept;
`ifdef UART_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  // With both pending, the requester not served last wins; otherwise the lone one.
  assign sel    = (req_if.req0_valid && req_if.req1_valid) ? ~rr_last_q : req_if.req1_valid;
  assign accept = (state_q == IDLE) && (req_if.req0_valid || req_if.req1_valid);

  assign req_if.req0_ready = accept && !sel;
  assign req_if.req1_ready = accept && sel;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_d != state_q),
    .enable_i (state_q != IDLE),
    .tc_o     (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (tc) state_d = DATA;
`ifdef UART_PARITY_EN
      DATA:    if (tc && (bit_idx_q == LAST_BIT)) state_d = PARITY;
      PARITY:  if (tc) state_d = STOP;
`else
      DATA:    if (tc && (bit_idx_q == LAST_BIT)) state_d = STOP;
`endif
      STOP:    if (tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // txd/busy are computed from the next state so the registered line changes
  // on the same edge as the state it belongs to.
  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    txd_d     = 1'b1;
    if (accept) begin
      shift_d   = sel ? req_if.req1_data : req_if.req0_data;
      bit_idx_d = '0;
      grant_d   = sel;
      rr_last_d = sel;
    end else if ((state_q == DATA) && tc) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = bit_idx_q + 3'd1;
    end
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

`ifdef UART_PARITY_EN
  assign parity_d = accept ? even_parity(shift_d) : parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule
